fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage that drives the instruction memory. Holds the PC, drives
//   imem_addr, and captures imem_rdata into an IF/ID register together with the PC that
//   fetched it. Supports start/halt control, pipeline stall, branch/jump redirect with flush,
//   and a fetch counter. Upstream of decode, and the only driver of InstMemory.address.
// PARAMETERS
//   ADDR_W   5    word-address width; matches InstMemory DEPTH=32 (word addressed, +1 per instr)
//   DATA_W   64   instruction word width; matches InstMemory BITS
//   RESET_PC 0    PC value loaded on reset
//   CNT_W    32   fetch_count width
// PORTS
//   clk          in   1       clock; all state updates on rising edge
//   rst          in   1       asynchronous, active-high reset
//   start        in   1       pulse: IDLE/HALT -> RUN
//   halt         in   1       pulse: RUN -> HALT
//   stall        in   1       hold PC and IF/ID register (decode not ready)
//   redirect     in   1       branch/jump taken; load redirect_pc, flush IF/ID
//   redirect_pc  in   ADDR_W  redirect target word address
//   imem_addr    out  ADDR_W  to InstMemory.address; equals pc (combinational)
//   imem_rdata   in   DATA_W  from InstMemory.readData; combinational, valid same cycle
//   if_instr     out  DATA_W  registered instruction to decode
//   if_pc        out  ADDR_W  registered PC of if_instr
//   if_valid     out  1       if_instr/if_pc hold a live instruction
//   running      out  1       1 when state == RUN
//   fetch_count  out  CNT_W   number of instructions latched with if_valid=1
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, pc=RESET_PC, if_instr=0, if_pc=0, if_valid=0,
//     fetch_count=0, running=0. Reset mid-fetch discards IF/ID contents; no partial updates.
//   FSM states IDLE, RUN, HALT (registered):
//     IDLE --start--> RUN; HALT --start--> RUN; RUN --halt--> HALT. Otherwise stay.
//     start and halt in same cycle: halt wins (RUN->HALT; IDLE/HALT stay put).
//   imem_addr = pc at all times. Fetch latency: instruction at pc appears on if_instr one
//     cycle after pc is presented.
//   Per-edge update priority in RUN (first match applies):
//     1 halt      : if_valid<=0; pc holds; enter HALT.
//     2 redirect  : pc<=redirect_pc; if_valid<=0 (flush). Redirect overrides stall.
//     3 stall     : pc, if_instr, if_pc, if_valid, fetch_count all hold.
//     4 normal    : if_instr<=imem_rdata; if_pc<=pc; if_valid<=1; pc<=pc+1;
//                   fetch_count<=fetch_count+1.
//   IDLE/HALT: if_valid<=0; fetch_count holds; pc holds except redirect loads redirect_pc
//     (lets controller set entry point before start). stall ignored.
//   PC arithmetic modulo 2^ADDR_W: pc=2^ADDR_W-1 wraps to 0, no flag.
//   fetch_count wraps modulo 2^CNT_W.
//   if_instr/if_pc keep last value when if_valid drops (not cleared); consumers use if_valid.
//   running is registered state decode, not combinational from start/halt.
// TESTING
//   T1 reset/start: rst=1 then 0, start pulse; mem[k]=k*0x11 -> imem_addr 0,1,2..;
//      if_instr=0x00,0x11,0x22 with if_pc=0,1,2, if_valid=1 from 2nd edge after start.
//   T2 stall: in RUN at pc=3, stall=1 for 3 cycles -> pc=3, if_pc=2, fetch_count frozen;
//      release -> next if_pc=3.
//   T3 redirect: at pc=5 assert redirect, redirect_pc=20 (also stall=1) -> if_valid=0
//      next cycle, pc=20; following cycle if_pc=20, if_instr=mem[20].
//   T4 wrap: redirect_pc=30, run 4 fetches -> if_pc sequence 30,31,0,1; fetch_count +4.
//   T5 halt/resume: halt at pc=7 -> running=0, if_valid=0, pc stays 7 for 5 cycles;
//      start+halt same cycle stays HALT; start alone -> resumes fetching pc=7.
//   T6 async reset mid-RUN (between edges) -> outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the fetched word with its PC into the IF/ID register.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | out of reset, not fetching; redirect may preset the PC
//   ST_RUN  | fetching one instruction per cycle unless stalled/redirected
//   ST_HALT | stopped by halt; PC holds until start resumes fetching
module fetch_unit #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 64,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              running,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
    logic                if_valid_q, if_valid_d;
    logic [CNT_W-1:0]    fetch_count_q, fetch_count_d;

    // State register and IF/ID pipeline register; reset discards everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC_W;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            if_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_valid_q    <= if_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state and datapath update: halt > redirect > stall > normal fetch while running.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_valid_d    = if_valid_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d    = ST_HALT;
                    if_valid_d = 1'b0;
                end else if (redirect) begin
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    if_instr_d    = imem_rdata;
                    if_pc_d       = pc_q;
                    if_valid_d    = 1'b1;
                    pc_d          = pc_q + 1'b1;
                    fetch_count_d = fetch_count_q + 1'b1;
                end
            end
            ST_IDLE, ST_HALT: begin
                // halt beats a simultaneous start, so stopped states only leave on start alone
                if (start && !halt) state_d = ST_RUN;
                if_valid_d = 1'b0;
                if (redirect) pc_d = redirect_pc;
            end
            default: begin
                state_d    = ST_IDLE;
                if_valid_d = 1'b0;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_valid    = if_valid_q;
    assign fetch_count = fetch_count_q;
    assign running     = (state_q == ST_RUN);

endmodule
